// File: rtl/pipereg_stage.sv
// pipereg_stage: generic valid/ready pipeline-stage register carrying an
// opaque payload plus PC, with synchronous flush (bubble insertion) and a
// saturating stall counter.
//
// Build option: define PIPEREG_STAGE_SKID_EN to add a one-entry skid buffer.
// This makes in_ready a pure register output, so there is no combinational
// path from out_ready, and the stage can hold two entries. Without the
// macro, in_ready is ~out_valid | out_ready and the stage holds one entry.
//
// While the stage holds a bubble, out_data is forced to zero and out_pc to
// BUBBLE_PC. This is done in the register itself, so every output is a
// flop output.

module pipereg_stage #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned PC_W      = 64,
  parameter logic [63:0] BUBBLE_PC = 64'h8000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Bubble PC truncated to the configured PC width.
  localparam logic [PC_W-1:0] BUBBLE_PC_T = PC_W'(BUBBLE_PC);

  // Main (output) register.
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [PC_W-1:0]   pc_q,    pc_d;

  // Stall counter.
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Handshake terms.
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

`ifdef PIPEREG_STAGE_SKID_EN

  // Skid register: holds the entry accepted while main was full and stalled.
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;

  // Upstream ready depends only on skid occupancy, so it is a flop output.
  assign in_ready = ~skid_valid_q;

  // Next-state for main and skid registers. Flush wins, then a full skid
  // refills main as it drains, then new entries go to main if it is free
  // this cycle or to skid otherwise.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    pc_d         = pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      valid_d      = 1'b0;
      data_d       = '0;
      pc_d         = BUBBLE_PC_T;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_pc_d    = BUBBLE_PC_T;
    end else if (skid_valid_q) begin
      // in_ready is low here, so no new entry can arrive this cycle.
      if (out_fire) begin
        valid_d      = 1'b1;
        data_d       = skid_data_q;
        pc_d         = skid_pc_q;
        skid_valid_d = 1'b0;
        skid_data_d  = '0;
        skid_pc_d    = BUBBLE_PC_T;
      end
    end else if (in_fire) begin
      if (!valid_q || out_ready) begin
        // Main is empty or draining: bypass the skid, keeping latency at 1.
        valid_d = 1'b1;
        data_d  = in_data;
        pc_d    = in_pc;
      end else begin
        // Main is full and stalled: park the entry behind it.
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_pc_d    = in_pc;
      end
    end else if (out_fire) begin
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = BUBBLE_PC_T;
    end
  end

  // Skid storage with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= BUBBLE_PC_T;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`else

  // Single-entry stage: accept when empty or when the held entry leaves now.
  assign in_ready = ~valid_q | out_ready;

  // Next-state for the main register: flush, then load, then drain, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;

    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = BUBBLE_PC_T;
    end else if (in_fire) begin
      valid_d = 1'b1;
      data_d  = in_data;
      pc_d    = in_pc;
    end else if (out_fire) begin
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = BUBBLE_PC_T;
    end
  end

`endif

  // Stall counter: counts stalled cycles with a valid entry, except on a
  // flush edge, and sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Main register and stall counter with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      pc_q        <= BUBBLE_PC_T;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_pc     = pc_q;
  assign out_bubble = ~valid_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/pipereg_stage.md
Name: pipereg_stage

Overview:
- Generic parametrised pipeline-stage register for the in-order core; replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload plus PC between two stages using a valid/ready handshake, with synchronous flush (bubble insertion) and a saturating stall counter.
- Optionally includes a one-entry skid buffer so upstream ready is purely registered.

Parameters:
DATA_W, 128, payload width in bits (stage control and data bundle, excluding PC)
PC_W, 64, PC width
BUBBLE_PC, 64'h8000_0000, PC value presented while the stage holds a bubble (truncated to PC_W)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush; squashes all held entries this cycle
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream payload
in_pc  in  PC_W  upstream PC
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  payload
out_pc  out  PC_W  PC; BUBBLE_PC when out_valid=0
out_bubble  out  1  equals ~out_valid
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_bubble=1, out_data=0, out_pc=BUBBLE_PC, stall_cnt=0, skid empty. in_ready=1 with SKID_EN defined; without it, in_ready is combinational and evaluates to 1. State holds its reset values until the first rising edge after reset returns to 1.
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Main register, without flush:
  - in_fire: loads in_data/in_pc and sets out_valid=1 on the next edge.
  - out_fire without in_fire: clears out_valid; out_data is set to 0 and out_pc to BUBBLE_PC.
  - Otherwise the register holds. Data never changes while out_valid=1 and out_ready=0.
- in_ready without SKID_EN: ~out_valid | out_ready (combinational path from out_ready). Latency in to out is 1 cycle; full throughput.
- Flush: highest priority. On an edge with flush=1:
  - out_valid=0, out_data=0, out_pc=BUBBLE_PC; skid cleared.
  - Any in_fire that cycle is discarded (the entry is lost, not held).
  - stall_cnt is not incremented that cycle.
  - in_ready is unaffected by flush in the same cycle.
- Bubble: out_bubble = ~out_valid at all times. out_data/out_pc are zero/BUBBLE_PC whenever out_valid=0.
- stall_cnt: +1 on each edge where out_valid=1, out_ready=0 and flush=0. Saturates at all-ones and never wraps. Cleared only by reset.
- in_valid must hold stable until in_fire; payload changes while in_valid=1 and in_ready=0 are a protocol violation and are not checked.

Optional Feature:
Macro: PIPEREG_STAGE_SKID_EN
- Defined:
  - Adds a one-entry skid register; in_ready = ~skid_valid and is registered, with no combinational path from out_ready.
  - Main full, out_ready=0, in_fire: the entry goes to skid; in_ready drops next cycle.
  - Main drains (out_fire) with skid full: skid moves to main the next edge and skid_valid clears.
  - Main empty or draining with skid empty: in_fire loads main directly.
  - Ordering strictly FIFO; capacity 2 entries; latency 1 cycle when skid is empty.
  - Flush clears both entries.
- Undefined: no skid storage; in_ready is combinational as above; capacity 1.

Test Plan:
- Reset: hold reset=0 for 3 cycles, toggle inputs -> out_valid=0, out_pc=64'h8000_0000, out_data=0, stall_cnt=0; release reset -> same values until first in_fire.
- Streaming: in_valid=1 continuously with pc 0x1000, 0x1004, 0x1008, out_ready=1 -> out_pc matches each one cycle later, no gaps, stall_cnt stays 0.
- Backpressure: entry pc 0x2000 held, out_ready=0 for 5 cycles -> out_pc/out_data stable, stall_cnt=5. Without skid, in_ready=0; with SKID_EN, a second entry 0x2004 is accepted, then in_ready=0. Release -> 0x2000 then 0x2004 emerge in order.
- Flush with concurrent input: out_valid=1, skid full, flush=1 and in_valid=1 with pc 0x3000 in the same cycle -> next cycle out_valid=0, out_bubble=1, out_pc=64'h8000_0000; 0x3000 never appears on the output.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with a valid entry -> stall_cnt reaches 15 and holds at 15.
- Async reset mid-operation: assert reset=0 between clock edges while stalled with 2 entries -> outputs return to reset values immediately, without waiting for a clock edge; no stale entry emerges after release.
